mem_bus_arbiter: RTL and testbench

//  Shares one single-port 256x16 RAM (1-cycle read latency) between the cpu memory port and a

---
 rtl/mem_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares a single-port 256x16 RAM between the cpu memory port and a debug/loader port,
// and decodes the memory-mapped switch/LED registers in the cpu address space.
module mem_bus_arbiter #(
    parameter int unsigned          data_width = 16,
    parameter int unsigned          addr_width = 9,
    parameter logic [addr_width-1:0] LED_ADDR  = 9'h100,
    parameter logic [addr_width-1:0] SW_ADDR   = 9'h140
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            cpu_mem_cmd,
    input  logic [addr_width-1:0] cpu_mem_addr,
    input  logic [data_width-1:0] cpu_wdata,
    output logic [data_width-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [7:0]            dbg_addr,
    input  logic [data_width-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_valid,
    output logic [data_width-1:0] dbg_rdata,
    output logic [7:0]            ram_addr,
    output logic                  ram_write,
    output logic [data_width-1:0] ram_din,
    input  logic [data_width-1:0] ram_dout,
    input  logic [7:0]            SW,
    output logic [7:0]            LEDR
);

    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;
    localparam logic       WIN_CPU = 1'b0;
    localparam logic       WIN_DBG = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CPU_RD = 2'd1,
        S_DBG_RD = 2'd2
    } state_t;

    state_t                state;
    logic                  last_winner;
    logic                  rd_io;
    logic [data_width-1:0] io_data;
    logic [data_width-1:0] cpu_rdata_q;
    logic [data_width-1:0] dbg_rdata_q;

    logic cpu_req, cpu_is_wr, cpu_io, dbg_act, idle;
    logic cpu_win, dbg_win, cpu_ram_wr, dbg_ram_wr;

    // Requests are masked during reset so nothing is granted or written in that cycle.
    always_comb begin
        cpu_req    = !reset && (cpu_mem_cmd == MREAD || cpu_mem_cmd == MWRITE);
        cpu_is_wr  = (cpu_mem_cmd == MWRITE);
        cpu_io     = cpu_mem_addr[addr_width-1];
        dbg_act    = !reset && dbg_req;
        idle       = (state == S_IDLE);
        cpu_win    = idle && cpu_req && (!dbg_act || last_winner == WIN_DBG);
        dbg_win    = idle && dbg_act && !cpu_win;
        cpu_ram_wr = cpu_win && cpu_is_wr && !cpu_io;
        dbg_ram_wr = dbg_win && dbg_we;
    end

    // RAM port and handshake outputs, driven in the grant cycle.
    always_comb begin
        ram_addr  = 8'h00;
        ram_din   = '0;
        ram_write = cpu_ram_wr || dbg_ram_wr;
        if (cpu_win && !cpu_io) begin
            ram_addr = cpu_mem_addr[7:0];
            if (cpu_is_wr) ram_din = cpu_wdata;
        end else if (dbg_win) begin
            ram_addr = dbg_addr;
            if (dbg_we) ram_din = dbg_wdata;
        end
        dbg_gnt   = dbg_win;
        dbg_valid = (state == S_DBG_RD);
        cpu_stall = cpu_req && !((cpu_win && cpu_is_wr) || state == S_CPU_RD);
        cpu_rdata = cpu_rdata_q;
        if (state == S_CPU_RD) cpu_rdata = rd_io ? io_data : ram_dout;
        dbg_rdata = dbg_valid ? ram_dout : dbg_rdata_q;
    end

    // Arbitration FSM; read data is held after the one-cycle read state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            last_winner <= WIN_DBG;
            rd_io       <= 1'b0;
            io_data     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            LEDR        <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_win) begin
                        last_winner <= WIN_CPU;
                        if (cpu_is_wr) begin
                            if (cpu_io && cpu_mem_addr == LED_ADDR) LEDR <= cpu_wdata[7:0];
                        end else begin
                            state   <= S_CPU_RD;
                            rd_io   <= cpu_io;
                            io_data <= (cpu_io && cpu_mem_addr == SW_ADDR)
                                       ? data_width'({8'h00, SW}) : '0;
                        end
                    end else if (dbg_win) begin
                        last_winner <= WIN_DBG;
                        if (!dbg_we) state <= S_DBG_RD;
                    end
                end
                S_CPU_RD: begin
                    cpu_rdata_q <= cpu_rdata;
                    state       <= S_IDLE;
                end
                S_DBG_RD: begin
                    dbg_rdata_q <= ram_dout;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural 256x16 RAM (1-cycle read latency).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cpu_mem_cmd;
    logic [8:0]  cpu_mem_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [7:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_valid;
    logic [15:0] dbg_rdata;
    logic [7:0]  ram_addr;
    logic        ram_write;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [7:0]  SW;
    logic [7:0]  LEDR;

    logic [15:0] mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_mem_cmd(cpu_mem_cmd), .cpu_mem_addr(cpu_mem_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_valid(dbg_valid), .dbg_rdata(dbg_rdata),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout),
        .SW(SW), .LEDR(LEDR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle mid-cycle before sampling.
    task automatic settle();
        #3;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        ram_dout = 16'h0000;
        reset = 1'b1; cpu_mem_cmd = 2'b00; cpu_mem_addr = 9'h000; cpu_wdata = 16'h0000;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 16'h0000; SW = 8'h00;
        tick(); tick();
        reset = 1'b0;
        settle();
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_ledr", 32'(LEDR), 32'h00);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0000);
        check("rst_dbg_rdata", 32'(dbg_rdata), 32'h0000);
        check("rst_dbg_valid", 32'(dbg_valid), 32'd0);
        check("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("rst_ram_write", 32'(ram_write), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'h00);

        // cpu RAM write then read back
        tick();
        cpu_mem_cmd = 2'b10; cpu_mem_addr = 9'h010; cpu_wdata = 16'hBEEF;
        settle();
        check("wr_ram_write", 32'(ram_write), 32'd1);
        check("wr_ram_addr", 32'(ram_addr), 32'h10);
        check("wr_ram_din", 32'(ram_din), 32'hBEEF);
        check("wr_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_mem_cmd = 2'b01;
        settle();
        check("rd_grant_stall", 32'(cpu_stall), 32'd1);
        check("rd_grant_ram_write", 32'(ram_write), 32'd0);
        check("rd_grant_ram_addr", 32'(ram_addr), 32'h10);
        tick();
        settle();
        check("rd_done_stall", 32'(cpu_stall), 32'd0);
        check("rd_done_rdata", 32'(cpu_rdata), 32'hBEEF);
        cpu_mem_cmd = 2'b00;
        tick();
        settle();
        check("rd_hold_rdata", 32'(cpu_rdata), 32'hBEEF);
        check("idle_ram_addr", 32'(ram_addr), 32'h00);

        // LED write goes to the register, not the RAM
        cpu_mem_cmd = 2'b10; cpu_mem_addr = 9'h100; cpu_wdata = 16'h00A5;
        settle();
        check("led_ram_write", 32'(ram_write), 32'd0);
        check("led_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_mem_cmd = 2'b00;
        settle();
        check("led_value", 32'(LEDR), 32'hA5);
        check("led_ram_write_after", 32'(ram_write), 32'd0);

        // Switch read and unmapped I/O read
        tick();
        SW = 8'b0001_1011;
        cpu_mem_cmd = 2'b01; cpu_mem_addr = 9'h140;
        settle();
        check("sw_grant_stall", 32'(cpu_stall), 32'd1);
        tick();
        settle();
        check("sw_rdata", 32'(cpu_rdata), 32'h001B);
        check("sw_done_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_mem_addr = 9'h1FF;
        settle();
        check("io_other_stall", 32'(cpu_stall), 32'd1);
        tick();
        settle();
        check("io_other_rdata", 32'(cpu_rdata), 32'h0000);
        cpu_mem_cmd = 2'b00;
        tick();

        // Debug port loads words 0..7 on consecutive cycles
        dbg_req = 1'b1; dbg_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 8'(i); dbg_wdata = 16'hA000 + 16'(i);
            settle();
            check("load_gnt", 32'(dbg_gnt), 32'd1);
            check("load_ram_write", 32'(ram_write), 32'd1);
            check("load_ram_addr", 32'(ram_addr), 32'(i));
            tick();
        end
        dbg_req = 1'b0; dbg_we = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            dbg_req = 1'b1; dbg_addr = 8'(i);
            settle();
            check("dbg_rd_gnt", 32'(dbg_gnt), 32'd1);
            tick();
            dbg_req = 1'b0;
            settle();
            check("dbg_rd_valid", 32'(dbg_valid), 32'd1);
            check("dbg_rd_data", 32'(dbg_rdata), 32'hA000 + 32'(i));
            tick();
            settle();
            check("dbg_rd_valid_pulse", 32'(dbg_valid), 32'd0);
            check("dbg_rd_hold", 32'(dbg_rdata), 32'hA000 + 32'(i));
        end

        // Reset during the cpu read-completion cycle
        cpu_mem_cmd = 2'b01; cpu_mem_addr = 9'h005;
        settle();
        check("rstrd_grant_stall", 32'(cpu_stall), 32'd1);
        tick();
        reset = 1'b1; cpu_mem_cmd = 2'b00;
        tick();
        reset = 1'b0;
        settle();
        check("rstrd_stall", 32'(cpu_stall), 32'd0);
        check("rstrd_ledr", 32'(LEDR), 32'h00);
        check("rstrd_dbg_valid", 32'(dbg_valid), 32'd0);
        check("rstrd_cpu_rdata", 32'(cpu_rdata), 32'h0000);

        // Simultaneous requests from reset: cpu first, then alternation
        cpu_mem_cmd = 2'b01; cpu_mem_addr = 9'h001;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h02;
        settle();
        check("rr1_stall", 32'(cpu_stall), 32'd1);
        check("rr1_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("rr1_ram_addr", 32'(ram_addr), 32'h01);
        tick();
        settle();
        check("rr2_cpu_rdata", 32'(cpu_rdata), 32'hA001);
        check("rr2_stall", 32'(cpu_stall), 32'd0);
        check("rr2_dbg_gnt", 32'(dbg_gnt), 32'd0);
        tick();
        settle();
        check("rr3_dbg_gnt", 32'(dbg_gnt), 32'd1);
        check("rr3_stall", 32'(cpu_stall), 32'd1);
        check("rr3_ram_addr", 32'(ram_addr), 32'h02);
        tick();
        settle();
        check("rr4_dbg_valid", 32'(dbg_valid), 32'd1);
        check("rr4_dbg_rdata", 32'(dbg_rdata), 32'hA002);
        check("rr4_stall", 32'(cpu_stall), 32'd1);
        tick();
        settle();
        check("rr5_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("rr5_ram_addr", 32'(ram_addr), 32'h01);
        tick();
        settle();
        check("rr6_stall", 32'(cpu_stall), 32'd0);
        tick();
        settle();
        check("rr7_dbg_gnt", 32'(dbg_gnt), 32'd1);
        cpu_mem_cmd = 2'b00; dbg_req = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
